keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad, synchronises and debounces the column returns, and emits
//  one-cycle key events with a 4-bit key code. Sits directly upstream of the game FSM.
//  The FSM treats key_pressed as a single-cycle strobe and reads value in that same cycle.
// PARAMETERS
//  ROW_DWELL_CYCLES  50000  clk cycles each row is driven (1 ms at 50 MHz); minimum 4
//  DEBOUNCE_PASSES   5      consecutive identical full-scan results needed to accept a press or release; minimum 1
// PORTS
//  clk          in   1  system clock; single clock domain
//  rst          in   1  synchronous, active-high reset
//  row          out  4  row drive, active-low one-hot (exactly one bit 0)
//  col          in   4  column return, active-low, externally pulled up, asynchronous
//  value        out  4  code of the last accepted key
//  key_pressed  out  1  1-cycle strobe: a new key press was accepted; value is valid in that cycle
// BEHAVIOUR
//  Reset: row=4'b1110, value=0, key_pressed=0, internal state IDLE, all counters 0, synchroniser flops 4'b1111.
//  Key map [row][col], codes: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D.
//    Digits map to 0-9, A=10, B=11, C=12, D=13, *=14, #=15.
//  col passes through a 2-flop synchroniser before any use.
//  Scan: a dwell counter runs 0..ROW_DWELL_CYCLES-1 per row.
//    The synchronised col is sampled on the last dwell cycle.
//    Then row rotates 1110->1101->1011->0111->1110. One pass = 4 rows.
//  Pass result, latched at the end of row 3:
//    NONE   no low column seen
//    ONE    exactly one low bit across all 4 samples; carries that key's code
//    MULTI  two or more low bits; treated as NONE for press detection, but does not count as released
//  FSM, evaluated once per pass end:
//    IDLE:    ONE(c) -> CAND with cand=c, cnt=1. If DEBOUNCE_PASSES==1, go straight to HELD and strobe.
//    CAND:    ONE(cand) -> cnt+1. When cnt reaches DEBOUNCE_PASSES: value<=cand, key_pressed=1 for one
//             cycle, -> HELD.
//             ONE(other) -> restart CAND with the new code, cnt=1. NONE/MULTI -> IDLE.
//    HELD:    NONE -> cnt+1; at DEBOUNCE_PASSES -> IDLE. ONE/MULTI -> cnt=0 and stay in HELD.
//             A second key pressed while the first is still held never produces an event.
//  Latency: the strobe comes on the cycle after the pass end that completes the count.
//    Worst case from a stable press = (DEBOUNCE_PASSES+1)*4*ROW_DWELL_CYCLES + 3 cycles.
//  key_pressed is never high on two consecutive cycles. value changes only on a strobe.
//  Auto-repeat: none. Holding a key gives exactly one event.
//  Counter widths: $clog2(ROW_DWELL_CYCLES) and $clog2(DEBOUNCE_PASSES+1). Counters saturate, never wrap.
//  rst mid-scan or mid-debounce: every register returns to its reset value next cycle.
//    No strobe is issued during or on the cycle after rst.
// STRUCTURE
//  Shared package keypad_pkg:
//    key code constants KEY_0..KEY_9, KEY_A=4'd10, KEY_B=4'd11, KEY_C=4'd12, KEY_D=4'd13,
//      KEY_STAR=4'd14, KEY_HASH=4'd15
//    the 4x4 code table function
//    scan FSM state enum (IDLE, CAND, HELD)
//  Sub-module keypad_sync2: 4-bit 2-flop synchroniser, reset to 1s.
//  Everything else is inline: dwell counter, row rotator, pass accumulator, debounce FSM.
// TESTING (ROW_DWELL_CYCLES=4, DEBOUNCE_PASSES=3; bench keypad model ties col low when its row is driven)
//  1. Reset: hold rst 3 cycles with key '5' down.
//     -> row=1110, value=0, key_pressed=0 throughout; rows rotate every 4 cycles after release.
//  2. Clean press of 'A' held 10 passes.
//     -> exactly one strobe with value=10, within 4 passes of the press; no further strobes while held.
//  3. Bouncy '7': toggled every 5 cycles for 2 passes, then stable.
//     -> single strobe with value=7 only after 3 stable passes.
//  4. Press '3', release 1 pass, press '3' again.
//     -> one strobe only, since the release was not debounced.
//     Release 3 passes then press again -> second strobe with value=3.
//  5. Hold 'D', then add '#' (MULTI) for 5 passes, release both, then press '#'.
//     -> events only for D (13), then # (15); nothing during MULTI.
//  6. Assert rst on the cycle before a strobe would fire.
//     -> no strobe, value stays 0; press is re-detected from IDLE after rst drops.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, keypad code table and scan FSM states
package keypad_pkg;
    localparam logic [3:0] KEY_0 = 4'd0;
    localparam logic [3:0] KEY_1 = 4'd1;
    localparam logic [3:0] KEY_2 = 4'd2;
    localparam logic [3:0] KEY_3 = 4'd3;
    localparam logic [3:0] KEY_4 = 4'd4;
    localparam logic [3:0] KEY_5 = 4'd5;
    localparam logic [3:0] KEY_6 = 4'd6;
    localparam logic [3:0] KEY_7 = 4'd7;
    localparam logic [3:0] KEY_8 = 4'd8;
    localparam logic [3:0] KEY_9 = 4'd9;
    localparam logic [3:0] KEY_A = 4'd10;
    localparam logic [3:0] KEY_B = 4'd11;
    localparam logic [3:0] KEY_C = 4'd12;
    localparam logic [3:0] KEY_D = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Entry {row, col} lives at bits [{row, col}*4 +: 4]; highest index first
    localparam logic [63:0] KEY_MAP = {
        KEY_D, KEY_HASH, KEY_0, KEY_STAR,
        KEY_C, KEY_9,    KEY_8, KEY_7,
        KEY_B, KEY_6,    KEY_5, KEY_4,
        KEY_A, KEY_3,    KEY_2, KEY_1
    };

    typedef enum logic [1:0] {IDLE, CAND, HELD} scan_state_t;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c, 2'b00} +: 4];
    endfunction
endpackage

// File: rtl/keypad_sync2.sv
// keypad_sync2: 4-bit two-flop synchroniser for the idle-high column returns
module keypad_sync2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 4'hF;
            q <= 4'hF;
        end else begin
            meta <= d;
            q <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scan, per-pass column classification and debounced press strobe
module keypad_scanner #(
    parameter int ROW_DWELL_CYCLES = 50000,
    parameter int DEBOUNCE_PASSES = 5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] value,
    output logic       key_pressed
);
    import keypad_pkg::*;

    localparam int DW = $clog2(ROW_DWELL_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_PASSES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_PASSES - 1);

    logic [3:0] col_s, lows;
    logic [DW-1:0] dwell;
    logic [1:0] row_idx, c_idx, acc_n;
    logic [2:0] n_row, tot;
    logic [3:0] acc_code, pass_code, cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic last, pass_end, one, none, fire;
    scan_state_t state, state_n;

    keypad_sync2 u_sync (.clk(clk), .rst(rst), .d(col), .q(col_s));

    assign row = ~(4'b0001 << row_idx);
    assign last = dwell == DWELL_LAST;
    assign pass_end = last && row_idx == 2'd3;
    assign lows = ~col_s;
    assign n_row = 3'(lows[0]) + 3'(lows[1]) + 3'(lows[2]) + 3'(lows[3]);
    assign c_idx = lows[0] ? 2'd0 : lows[1] ? 2'd1 : lows[2] ? 2'd2 : 2'd3;
    // Running low-bit count saturates at 2: anything beyond one key is just MULTI
    assign tot = {1'b0, acc_n} + n_row;
    assign pass_code = acc_n == 2'd0 ? key_code(row_idx, c_idx) : acc_code;
    assign one = pass_end && tot == 3'd1;
    assign none = pass_end && tot == 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell <= '0;
            row_idx <= 2'd0;
            acc_n <= 2'd0;
            acc_code <= 4'd0;
            state <= IDLE;
            cnt <= '0;
            cand <= 4'd0;
            value <= 4'd0;
            key_pressed <= 1'b0;
        end else begin
            dwell <= last ? '0 : dwell + 1'b1;
            if (last) begin
                row_idx <= row_idx + 2'd1;
                acc_n <= pass_end ? 2'd0 : (tot > 3'd2 ? 2'd2 : tot[1:0]);
                acc_code <= pass_code;
            end
            state <= state_n;
            cnt <= cnt_n;
            cand <= cand_n;
            key_pressed <= fire;
            if (fire) value <= cand_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        cand_n = cand;
        fire = 1'b0;
        if (pass_end) begin
            case (state)
                IDLE: if (one) begin
                    cand_n = pass_code;
                    fire = DEBOUNCE_PASSES == 1;
                    state_n = fire ? HELD : CAND;
                    cnt_n = fire ? '0 : CW'(1);
                end
                CAND: if (one && pass_code == cand) begin
                    fire = cnt == CNT_LAST;
                    state_n = fire ? HELD : CAND;
                    cnt_n = fire ? '0 : cnt + 1'b1;
                end else if (one) begin
                    cand_n = pass_code;
                    cnt_n = CW'(1);
                end else begin
                    state_n = IDLE;
                    cnt_n = '0;
                end
                HELD: if (none) begin
                    state_n = cnt == CNT_LAST ? IDLE : HELD;
                    cnt_n = cnt == CNT_LAST ? '0 : cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with a matrix model and hand-computed expectations
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int DW = 4;
    localparam int DP = 3;
    localparam int PASS = 4 * DW;
    localparam int WORST = (DP + 1) * 4 * DW + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] row, col, value;
    logic key_pressed;
    logic [15:0] keys = '0;
    logic kp_prev = 1'b0;
    int checks = 0, errors = 0, strobes = 0, consec = 0, cyc = 0, strobe_cyc = 0;
    int base, press, n;

    always #5 clk = ~clk;

    keypad_scanner #(.ROW_DWELL_CYCLES(DW), .DEBOUNCE_PASSES(DP)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .value(value), .key_pressed(key_pressed)
    );

    // keys[r*4+c] pressed pulls column c low while row r is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row[r]) col = col & ~keys[r*4 +: 4];
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        kp_prev <= key_pressed;
        if (key_pressed) begin
            strobes <= strobes + 1;
            strobe_cyc <= cyc;
        end
        if (key_pressed && kp_prev) consec <= consec + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic passes(input int p);
        repeat (p * PASS) @(negedge clk);
    endtask

    initial begin
        keys[5] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_row", 32'(row), 32'(4'b1110));
            check("rst_value", 32'(value), 0);
            check("rst_strobe", 32'(key_pressed), 0);
        end
        rst = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        check("row0_dwell", 32'(row), 32'(4'b1110));
        @(negedge clk);
        check("row1", 32'(row), 32'(4'b1101));
        repeat (4) @(negedge clk);
        check("row2", 32'(row), 32'(4'b1011));
        repeat (4) @(negedge clk);
        check("row3", 32'(row), 32'(4'b0111));
        repeat (4) @(negedge clk);
        check("row_wrap", 32'(row), 32'(4'b1110));
        passes(4);
        check("rst_no_event", 32'(strobes), 0);

        do_reset();
        base = strobes;
        press = cyc;
        keys[3] = 1'b1;
        passes(10);
        check("a_count", 32'(strobes - base), 1);
        check("a_value", 32'(value), 32'(KEY_A));
        check("a_latency", 32'((strobe_cyc - press) <= 4 * PASS), 1);
        keys = '0;
        passes(5);
        check("a_release_count", 32'(strobes - base), 1);
        check("a_release_value", 32'(value), 32'(KEY_A));

        do_reset();
        base = strobes;
        for (int i = 0; i < 6; i++) begin
            keys[8] = ~keys[8];
            repeat (5) @(negedge clk);
        end
        keys[8] = 1'b1;
        check("bounce_quiet", 32'(strobes - base), 0);
        passes(2);
        check("bounce_two_stable", 32'(strobes - base), 0);
        passes(3);
        check("bounce_count", 32'(strobes - base), 1);
        check("bounce_value", 32'(value), 32'(KEY_7));
        keys = '0;

        do_reset();
        base = strobes;
        keys[2] = 1'b1;
        passes(5);
        check("k3_first", 32'(strobes - base), 1);
        check("k3_value", 32'(value), 32'(KEY_3));
        keys[2] = 1'b0;
        passes(1);
        keys[2] = 1'b1;
        passes(5);
        check("k3_short_release", 32'(strobes - base), 1);
        keys = '0;
        passes(5);
        keys[2] = 1'b1;
        passes(5);
        check("k3_second", 32'(strobes - base), 2);
        check("k3_value2", 32'(value), 32'(KEY_3));
        keys = '0;

        do_reset();
        base = strobes;
        keys[15] = 1'b1;
        passes(5);
        check("d_count", 32'(strobes - base), 1);
        check("d_value", 32'(value), 32'(KEY_D));
        keys[14] = 1'b1;
        passes(5);
        check("multi_quiet", 32'(strobes - base), 1);
        check("multi_value", 32'(value), 32'(KEY_D));
        keys = '0;
        passes(5);
        check("multi_release", 32'(strobes - base), 1);
        keys[14] = 1'b1;
        passes(5);
        check("hash_count", 32'(strobes - base), 2);
        check("hash_value", 32'(value), 32'(KEY_HASH));
        keys = '0;

        do_reset();
        keys[0] = 1'b1;
        n = 0;
        while (!key_pressed && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("measure_seen", 32'(key_pressed), 1);
        check("latency_bound", 32'(n <= WORST), 1);
        check("measure_value", 32'(value), 32'(KEY_1));
        keys = '0;
        do_reset();
        keys[0] = 1'b1;
        base = strobes;
        repeat (n - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_blocks_strobe", 32'(key_pressed), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_strobe", 32'(key_pressed), 0);
        check("post_rst_value", 32'(value), 0);
        check("blocked_count", 32'(strobes - base), 0);
        passes(5);
        check("redetect_count", 32'(strobes - base), 1);
        check("redetect_value", 32'(value), 32'(KEY_1));
        keys = '0;

        @(negedge clk);
        check("no_back_to_back", 32'(consec), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
